// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the latched request.
package lsu_pkg;

    localparam int WORD_OFF_BITS = 2;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} lsu_size_e;

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} lsu_state_e;

    typedef struct packed {
        logic                     we;
        lsu_size_e                size;
        logic                     uns;
        logic [WORD_OFF_BITS-1:0] off;
        logic [31:0]              wdata;
    } lsu_req_t;

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response channel from the execute stage, and the single-port word memory bus.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface lsu_mem_if #(parameter int DATA_W = 32);
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rw;
    logic [31:0]       mem_rdata;

    modport master (output mem_addr, mem_wdata, mem_rw, input mem_rdata);
    modport slave  (input mem_addr, mem_wdata, mem_rw, output mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: sub-word load extraction/extension and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0]              word,
    input  logic [WORD_OFF_BITS-1:0] off,
    input  lsu_size_e                size,
    input  logic                     uns,
    input  logic [31:0]              wdata,
    output logic [31:0]              load_val,
    output logic [31:0]              store_word
);

    logic [3:0][7:0] lanes;
    logic [3:0][7:0] wlanes;
    logic [3:0][7:0] merged;
    logic [7:0]      b;
    logic [15:0]     h;

    assign lanes  = word;
    assign wlanes = wdata;
    assign b      = lanes[off];
    assign h      = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_val = '0;
        case (size)
            SZ_B:    load_val = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_H:    load_val = uns ? {16'h0, h} : {{16{h[15]}}, h};
            SZ_W:    load_val = word;
            default: load_val = '0;
        endcase
    end

    // Only the addressed lanes take new data; the rest keep the word read back from memory.
    always_comb begin
        merged = lanes;
        for (int i = 0; i < 4; i++) begin
            case (size)
                SZ_B:    if (off == 2'(i)) merged[i] = wlanes[0];
                SZ_H:    if (off[1] == i[1]) merged[i] = wlanes[i % 2];
                SZ_W:    merged[i] = wlanes[i];
                default: ;
            endcase
        end
    end

    assign store_word = merged;

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for a byte-enable-less word memory; sub-word stores go read-modify-write.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int MEM_ADDR_W = 8,
    parameter int DATA_W     = 32
) (
    input  logic      clk,
    input  logic      reset,
    mem_lsu_if.slave  lsu,
    lsu_mem_if.master mem
);

    lsu_state_e  state;
    lsu_req_t    rq;
    lsu_size_e   req_size;
    logic [31:0] word_q;
    logic [31:0] mem_addr_q;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic        accept;
    logic        req_err;

    assign req_size      = lsu_size_e'(lsu.req_size);
    assign lsu.req_ready = (state == IDLE) && !reset;
    assign accept        = lsu.req_valid && lsu.req_ready;

    // Out-of-range means any word-index bit above the memory depth is set.
    assign req_err = (req_size == SZ_BAD)
                  || (req_size == SZ_H && lsu.req_addr[0])
                  || (req_size == SZ_W && lsu.req_addr[1:0] != 2'b00)
                  || (|lsu.req_addr[31:MEM_ADDR_W+WORD_OFF_BITS]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rq          <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rq <= '{we: lsu.req_we, size: req_size, uns: lsu.req_unsigned,
                            off: lsu.req_addr[WORD_OFF_BITS-1:0], wdata: lsu.req_wdata};
                    if (req_err) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        mem_addr_q <= {2'b00, lsu.req_addr[31:WORD_OFF_BITS]};
                        state      <= (lsu.req_we && req_size == SZ_W) ? WR : RD;
                    end
                end
                RD:  state <= CAP;
                CAP: begin
                    word_q <= mem.mem_rdata;
                    if (rq.we) begin
                        state <= WR;
                    end else begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                WR: begin
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: if (lsu.rsp_ready) begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    lsu_align u_align (
        .word       (word_q),
        .off        (rq.off),
        .size       (rq.size),
        .uns        (rq.uns),
        .wdata      (rq.wdata),
        .load_val   (load_val),
        .store_word (merged)
    );

    // Response data is taken from the captured word, which holds still for the whole RESP state.
    assign lsu.rsp_valid = rsp_valid_q;
    assign lsu.rsp_err   = rsp_err_q;
    assign lsu.rsp_rdata = (state == RESP && !rq.we && !rsp_err_q) ? load_val : '0;

    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = (state == WR) ? DATA_W'(merged) : '0;
    assign mem.mem_rw    = (state == WR) && !reset;

endmodule
